mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (IF) and data load/store (DM) requesters.
- Sits between the fetch stage (PC address out, fetch-flush in) and the memory stage of the core; the memory model/interface sits below it.
- Data has priority over fetch, with a starvation guard that forces a fetch grant after STARVE_LIMIT consecutive data grants.
- At most one memory transaction outstanding; responses are routed back to the owning requester. Stale fetch responses are dropped on a fetch flush.

Parameters:
- STARVE_LIMIT, 4: consecutive DM grants with IF pending before IF is forced to win; legal range 1..15.
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- i_clk  input  1  global clock.
- i_rst  input  1  synchronous active-high reset.
- i_if_req  input  1  fetch request, held until granted or withdrawn.
- i_if_addr  input  32  fetch address.
- i_if_flush  input  1  PC redirect; discard any in-flight fetch response.
- o_if_gnt  output  1  fetch request accepted this cycle.
- o_if_rvalid  output  1  fetch data valid this cycle.
- o_if_rdata  output  32  fetch data.
- i_dm_req  input  1  data request.
- i_dm_wen  input  1  1 = store, 0 = load.
- i_dm_addr  input  32  data address.
- i_dm_wdata  input  32  store data.
- i_dm_mask  input  4  byte enables.
- o_dm_gnt  output  1  data request accepted this cycle.
- o_dm_rvalid  output  1  load data / store acknowledge valid.
- o_dm_rdata  output  32  load data.
- o_mem_req  output  1  request to memory.
- o_mem_wen  output  1  write enable to memory.
- o_mem_addr  output  32  address to memory.
- o_mem_wdata  output  32  write data to memory.
- o_mem_mask  output  4  byte enables to memory; 4'hF for fetch.
- i_mem_ready  input  1  memory accepts request when o_mem_req is high.
- i_mem_rvalid  input  1  response for the accepted request; one per request, including writes.
- i_mem_rdata  input  32  response data.

Behaviour:
- FSM states: IDLE, WAIT_IF, WAIT_DM. Reset puts the FSM in IDLE, clears the starvation counter to 0, and clears drop_ff to 0.
- Reset values: all o_*_gnt, o_*_rvalid and o_mem_req are 0. o_mem_wen is 0 and o_mem_mask is 0 while o_mem_req is 0. o_*_rdata = i_mem_rdata at all times (qualified by rvalid).
- IDLE arbitration is combinational:
  - force_if = (cnt >= STARVE_LIMIT).
  - winner = DM if i_dm_req and !(force_if and i_if_req); else IF if i_if_req; else none.
- o_mem_* mirror the winner's inputs. A fetch always drives wen=0 and mask=4'hF. o_mem_req = (winner != none) and state==IDLE.
- Grant: o_X_gnt = o_mem_req & i_mem_ready & winner==X. Next state is WAIT_X.
- No grant (ready low): state stays IDLE; winner is re-evaluated every cycle; requesters hold their request.
- Starvation counter:
  - On a DM grant with i_if_req high: cnt+1, saturating at STARVE_LIMIT.
  - On an IF grant: cnt = 0.
  - Otherwise: cnt holds.
- WAIT_X, response cycle (i_mem_rvalid=1): o_X_rvalid=1 (IF suppressed if drop_ff or i_if_flush). Next state is IDLE. No new request is issued in the response cycle, so the minimum cycle per access is latency+1.
- o_mem_req is 0 in both WAIT states; i_mem_rvalid is ignored in IDLE.
- drop_ff:
  - Set when i_if_flush is high in WAIT_IF, or in IDLE at an IF grant.
  - Cleared on leaving WAIT_IF.
  - i_if_flush in IDLE without an IF grant has no effect.
- DM responses are never dropped. For a store, o_dm_rvalid is an acknowledge and o_dm_rdata is don't-care.
- Simultaneous IF and DM requests with cnt < STARVE_LIMIT: DM wins.
- Reset asserted mid-transaction: return to IDLE next cycle and suppress rvalid. A late memory response is ignored; the memory side is reset together with the arbiter.

Test Plan:
- Fetch only, i_if_addr=0x100, ready=1, rvalid 2 cycles after grant with rdata=0x00500093. Required: o_if_gnt in cycle 0, o_if_rvalid in cycle 2 with 0x00500093, o_dm_rvalid stays 0, o_mem_mask=4'hF.
- IF and DM requesting simultaneously: DM store (addr 0x2000, wdata 0xDEADBEEF, mask 4'b0011) is granted first, o_mem_wen=1. IF is granted in the IDLE cycle after the DM ack.
- Starvation: IF held high while DM requests continuously, STARVE_LIMIT=4. Required: DM granted 4 times, 5th grant is IF, cnt returns to 0, then DM wins again.
- Fetch flush: i_if_flush pulsed 1 cycle after an IF grant. Required: the response arrives and o_if_rvalid stays 0. The next fetch (addr 0x200) returns its data normally.
- Backpressure: i_mem_ready=0 for 3 cycles with i_dm_req high. Required: no gnt, o_mem_req=1 and o_mem_addr stable throughout; gnt on the cycle ready rises.
- Reset in WAIT_DM: i_rst pulsed, then a late i_mem_rvalid arrives. Required: o_dm_rvalid=0, state IDLE, cnt=0, all outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data requesters
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_flush,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_dm_req,
  input  logic        i_dm_wen,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_mask,
  output logic        o_dm_gnt,
  output logic        o_dm_rvalid,
  output logic [31:0] o_dm_rdata,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             drop_ff, drop_nxt;
  logic             idle, force_if, dm_win, if_win;

  assign o_if_rdata = i_mem_rdata;
  assign o_dm_rdata = i_mem_rdata;

  // Arbitration only happens in IDLE; reset masks every request and response.
  always_comb begin
    idle     = (state == IDLE) && !i_rst;
    force_if = (cnt >= LIMIT);
    dm_win   = idle && i_dm_req && !(force_if && i_if_req);
    if_win   = idle && !dm_win && i_if_req;
  end

  always_comb begin
    o_mem_req   = dm_win || if_win;
    o_mem_wen   = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    o_mem_mask  = 4'h0;
    if (dm_win) begin
      o_mem_wen   = i_dm_wen;
      o_mem_addr  = i_dm_addr;
      o_mem_wdata = i_dm_wdata;
      o_mem_mask  = i_dm_mask;
    end else if (if_win) begin
      o_mem_addr  = i_if_addr;
      o_mem_mask  = 4'hF;
    end
    o_if_gnt    = if_win && i_mem_ready;
    o_dm_gnt    = dm_win && i_mem_ready;
    o_if_rvalid = !i_rst && (state == WAIT_IF) && i_mem_rvalid && !drop_ff && !i_if_flush;
    o_dm_rvalid = !i_rst && (state == WAIT_DM) && i_mem_rvalid;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    drop_nxt  = drop_ff;
    case (state)
      IDLE: begin
        if (o_dm_gnt) begin
          state_nxt = WAIT_DM;
          if (i_if_req) cnt_nxt = (cnt >= LIMIT) ? LIMIT : cnt + CNT_W'(1);
        end else if (o_if_gnt) begin
          state_nxt = WAIT_IF;
          cnt_nxt   = '0;
          drop_nxt  = i_if_flush;
        end
      end
      WAIT_IF: begin
        if (i_mem_rvalid) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
        end else if (i_if_flush) begin
          drop_nxt  = 1'b1;
        end
      end
      WAIT_DM: begin
        if (i_mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      drop_ff <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      drop_ff <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed checks of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req, i_if_flush, i_dm_req, i_dm_wen;
  logic [31:0] i_if_addr, i_dm_addr, i_dm_wdata;
  logic [3:0]  i_dm_mask;
  logic        o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid;
  logic [31:0] o_if_rdata, o_dm_rdata;
  logic        o_mem_req, o_mem_wen;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready, i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_dm_req(i_dm_req), .i_dm_wen(i_dm_wen), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .i_dm_mask(i_dm_mask),
    .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
    .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Transaction model: who owns the memory (0 none, 1 fetch, 2 data), run of data wins, drop flag.
  int   owner = 0;
  int   streak = 0;
  bit   dropped = 0;
  // Memory responder
  bit          mem_busy = 0;
  int          mem_left = 0;
  int          lat = 1;
  bit          force_rv = 0;
  logic [31:0] next_rdata = 32'h0;
  // Samples of the most recent checked cycle
  logic        s_if_gnt, s_dm_gnt, s_if_rv, s_dm_rv, s_mem_req, s_mem_wen;
  logic [31:0] s_mem_addr, s_rdata;
  logic [3:0]  s_mem_mask;

  task automatic cycle();
    int win;
    bit gnt;
    if (!force_rv) i_mem_rvalid = mem_busy && (mem_left == 0);
    i_mem_rdata = next_rdata;
    #1;
    win = 0;
    if (!i_rst && owner == 0) begin
      if (i_dm_req && !(i_if_req && streak >= LIMIT)) win = 2;
      else if (i_if_req) win = 1;
    end
    gnt = (win != 0) && i_mem_ready;
    check("mem_req", o_mem_req, win != 0);
    check("if_gnt", o_if_gnt, win == 1 && i_mem_ready);
    check("dm_gnt", o_dm_gnt, win == 2 && i_mem_ready);
    check("mem_wen", o_mem_wen, win == 2 ? i_dm_wen : 1'b0);
    check("mem_mask", o_mem_mask, win == 2 ? i_dm_mask : (win == 1 ? 4'hF : 4'h0));
    if (win == 2) begin
      check("mem_addr_dm", o_mem_addr, i_dm_addr);
      check("mem_wdata", o_mem_wdata, i_dm_wdata);
    end
    if (win == 1) check("mem_addr_if", o_mem_addr, i_if_addr);
    check("if_rvalid", o_if_rvalid, !i_rst && owner == 1 && i_mem_rvalid && !dropped && !i_if_flush);
    check("dm_rvalid", o_dm_rvalid, !i_rst && owner == 2 && i_mem_rvalid);
    if (o_if_rvalid) check("if_rdata", o_if_rdata, next_rdata);
    if (o_dm_rvalid) check("dm_rdata", o_dm_rdata, next_rdata);
    s_if_gnt = o_if_gnt; s_dm_gnt = o_dm_gnt; s_if_rv = o_if_rvalid; s_dm_rv = o_dm_rvalid;
    s_mem_req = o_mem_req; s_mem_wen = o_mem_wen; s_mem_addr = o_mem_addr;
    s_mem_mask = o_mem_mask; s_rdata = o_if_rvalid ? o_if_rdata : o_dm_rdata;
    @(posedge i_clk);
    if (i_rst) begin
      owner = 0; streak = 0; dropped = 0; mem_busy = 0;
    end else if (gnt) begin
      owner = win;
      if (win == 2 && i_if_req && streak < LIMIT) streak++;
      if (win == 1) begin
        streak = 0;
        dropped = i_if_flush;
      end
      mem_busy = 1; mem_left = lat - 1;
    end else if (owner != 0 && i_mem_rvalid) begin
      owner = 0; dropped = 0; mem_busy = 0;
    end else begin
      if (owner == 1 && i_if_flush) dropped = 1;
      if (mem_busy) mem_left--;
    end
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_if_req = 0; i_if_flush = 0; i_dm_req = 0; i_dm_wen = 0;
    i_if_addr = 0; i_dm_addr = 0; i_dm_wdata = 0; i_dm_mask = 0;
    i_mem_ready = 1;
  endtask

  initial begin
    i_rst = 1; i_mem_rvalid = 0; i_mem_rdata = 0;
    idle_inputs();
    cycle(); cycle();
    check("rst_mem_req", s_mem_req, 0);
    check("rst_mem_mask", s_mem_mask, 0);
    i_rst = 0;
    cycle();

    // Fetch only, 2-cycle latency
    lat = 2; i_if_req = 1; i_if_addr = 32'h100;
    cycle();
    check("t1_if_gnt", s_if_gnt, 1);
    check("t1_mask", s_mem_mask, 4'hF);
    i_if_req = 0;
    cycle();
    next_rdata = 32'h00500093;
    cycle();
    check("t1_if_rvalid", s_if_rv, 1);
    check("t1_if_rdata", s_rdata, 32'h00500093);
    check("t1_dm_rvalid", s_dm_rv, 0);

    // Simultaneous requests: data store wins, fetch follows the ack
    lat = 1; i_if_req = 1; i_if_addr = 32'h104;
    i_dm_req = 1; i_dm_wen = 1; i_dm_addr = 32'h2000; i_dm_wdata = 32'hDEADBEEF; i_dm_mask = 4'b0011;
    cycle();
    check("t2_dm_gnt", s_dm_gnt, 1);
    check("t2_wen", s_mem_wen, 1);
    check("t2_addr", s_mem_addr, 32'h2000);
    i_dm_req = 0; i_dm_wen = 0;
    cycle();
    check("t2_dm_ack", s_dm_rv, 1);
    cycle();
    check("t2_if_gnt", s_if_gnt, 1);
    i_if_req = 0;
    cycle();

    // Starvation guard: D D D D I D
    i_if_req = 1; i_if_addr = 32'h108; i_dm_req = 1; i_dm_addr = 32'h2004; i_dm_mask = 4'hF;
    for (int g = 0; g < 6; g++) begin
      cycle();
      check("t3_if_gnt", s_if_gnt, g == 4);
      check("t3_dm_gnt", s_dm_gnt, g != 4);
      cycle();
    end
    idle_inputs();
    cycle();

    // Flush one cycle after a fetch grant
    lat = 3; i_if_req = 1; i_if_addr = 32'h180;
    cycle();
    check("t4_if_gnt", s_if_gnt, 1);
    i_if_req = 0; i_if_flush = 1;
    cycle();
    i_if_flush = 0;
    cycle();
    next_rdata = 32'hBADBAD00;
    cycle();
    check("t4_dropped", s_if_rv, 0);
    lat = 2; i_if_req = 1; i_if_addr = 32'h200;
    cycle();
    i_if_req = 0;
    cycle();
    next_rdata = 32'h12345678;
    cycle();
    check("t4_next_rvalid", s_if_rv, 1);
    check("t4_next_rdata", s_rdata, 32'h12345678);

    // Backpressure
    lat = 1; i_dm_req = 1; i_dm_addr = 32'h3000; i_mem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t5_no_gnt", s_dm_gnt, 0);
      check("t5_req", s_mem_req, 1);
      check("t5_addr", s_mem_addr, 32'h3000);
    end
    i_mem_ready = 1;
    cycle();
    check("t5_gnt", s_dm_gnt, 1);
    i_dm_req = 0;
    cycle();

    // Reset while waiting for data, then a late response
    lat = 3; i_dm_req = 1; i_dm_addr = 32'h4000;
    cycle();
    i_dm_req = 0;
    cycle();
    i_rst = 1;
    cycle();
    check("t6_rst_rvalid", s_dm_rv, 0);
    i_rst = 0; force_rv = 1; i_mem_rvalid = 1;
    cycle();
    check("t6_late_rvalid", s_dm_rv, 0);
    check("t6_mem_req", s_mem_req, 0);
    check("t6_cnt", 32'(dut.cnt), 0);
    force_rv = 0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      i_rst       = ($urandom_range(0, 199) == 0);
      i_if_req    = ($urandom_range(0, 99) < 60);
      i_dm_req    = ($urandom_range(0, 99) < 60);
      i_if_flush  = ($urandom_range(0, 99) < 10);
      i_dm_wen    = $urandom_range(0, 1);
      i_if_addr   = $urandom;
      i_dm_addr   = $urandom;
      i_dm_wdata  = $urandom;
      i_dm_mask   = 4'($urandom);
      i_mem_ready = ($urandom_range(0, 99) < 70);
      lat         = $urandom_range(1, 3);
      next_rdata  = $urandom;
      force_rv    = !mem_busy && ($urandom_range(0, 99) < 5);
      if (force_rv) i_mem_rvalid = 1;
      cycle();
    end
    force_rv = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
